// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Bundles the pipeline request/response handshake and the memory
//            access controller command/data bus of the load/store unit.
//            slave  = load/store unit view, master = surrounding environment.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  // Pipeline request side
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Pipeline response side
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  // Memory access controller side
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    input  resp_ready,
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_cmd_ready, mem_rdata, mem_rdata_valid
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    output resp_ready,
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    output mem_cmd_ready, mem_rdata, mem_rdata_valid
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Decodes RV32I loads/stores, issues one memory controller command
//            per request, extends load data and returns a result through a
//            valid/ready handshake with error flag and timeout guard.
// Options  : define MISALIGN_TRAP_EN to reject misaligned half/word accesses
//            instead of passing them to the controller.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 1024  // 0 disables the timeout
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_READ  = 3'd2,
    S_WAIT_WRITE = 3'd3,
    S_RESP       = 3'd4,
    S_DRAIN      = 3'd5
  } state_t;

  localparam logic [16:0] c_timeout    = 17'(TIMEOUT_CYCLES);
  localparam bit          c_timeout_en = (TIMEOUT_CYCLES != 0);

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [15:0] r_tcnt;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic [31:0] w_load_data;
  logic        w_cmd_start;
  logic        w_cmd_write;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [31:0] w_mem_wmask;

  // Classify the incoming funct3: stores allow only 000..010, loads reject 011/110/111
  always_comb begin
    w_illegal = 1'b0;
    if (bus.req_write) begin
      w_illegal = (bus.req_funct3 > 3'b010);
    end else begin
      w_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111);
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Halfwords need addr[0]=0, words need addr[1:0]=0; byte accesses are always aligned
  assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  // Misaligned accesses go to the controller unchanged; it splits them itself
  assign w_misalign = 1'b0;
`endif

  // Timeout fires on the cycle that would bring the counter up to the limit
  assign w_timeout = c_timeout_en && (({1'b0, r_tcnt} + 17'd1) == c_timeout);

  // Sign/zero extension of the returned word according to the latched funct3
  always_comb begin
    w_load_data = bus.mem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      3'b100:  w_load_data = {24'h0, bus.mem_rdata[7:0]};
      3'b001:  w_load_data = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b101:  w_load_data = {16'h0, bus.mem_rdata[15:0]};
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  // Controller command and byte-lane data/mask; everything is quiet outside ISSUE
  always_comb begin
    w_cmd_start = 1'b0;
    w_cmd_write = 1'b0;
    w_mem_addr  = 32'h0;
    w_mem_wdata = 32'h0;
    w_mem_wmask = 32'h0;
    if (r_state == S_ISSUE) begin
      w_cmd_start = bus.mem_cmd_ready;
      w_cmd_write = r_write;
      w_mem_addr  = r_addr;
      if (r_write) begin
        case (r_funct3[1:0])
          2'b00: begin
            w_mem_wdata = {24'h0, r_wdata[7:0]};
            w_mem_wmask = 32'h0000_00ff;
          end
          2'b01: begin
            w_mem_wdata = {16'h0, r_wdata[15:0]};
            w_mem_wmask = 32'h0000_ffff;
          end
          default: begin
            w_mem_wdata = r_wdata;
            w_mem_wmask = 32'hffff_ffff;
          end
        endcase
      end
    end
  end

  assign bus.mem_cmd_start = w_cmd_start;
  assign bus.mem_cmd_write = w_cmd_write;
  assign bus.mem_addr      = w_mem_addr;
  assign bus.mem_wdata     = w_mem_wdata;
  assign bus.mem_wmask     = w_mem_wmask;

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_error = r_error;

  // Request sequencing: latch, issue, wait for completion or timeout, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_error  <= 1'b0;
      r_tcnt   <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_rdata  <= 32'h0;
            r_tcnt   <= 16'h0;
            if (w_illegal || w_misalign) begin
              r_error <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_error <= 1'b0;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_tcnt <= r_tcnt + 16'd1;
          if (bus.mem_cmd_ready) begin
            r_state <= r_write ? S_WAIT_WRITE : S_WAIT_READ;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_rdata <= 32'h0;
            r_state <= S_RESP;
          end
        end
        S_WAIT_READ: begin
          r_tcnt <= r_tcnt + 16'd1;
          if (bus.mem_rdata_valid) begin
            r_rdata <= w_load_data;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_rdata <= 32'h0;
            r_state <= S_DRAIN;
          end
        end
        S_WAIT_WRITE: begin
          r_tcnt <= r_tcnt + 16'd1;
          if (bus.mem_cmd_ready) begin
            r_rdata <= 32'h0;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_rdata <= 32'h0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Late read data is discarded; only the controller going idle matters
          if (bus.mem_cmd_ready) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
